// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: multicycle fetch/decode controller for a 16-bit ISA.
// It fetches one instruction per FETCH->DECODE->EXEC(->WB) pass. It holds the
// instruction in IR and drives the register-file selects, ALU controls and
// the PC.
//
// Fetch handshake: imem_req/imem_addr are held steady while in FETCH until a
// rising edge where imem_req and imem_ack are both high; that edge transfers
// imem_data into IR. imem_ack seen with imem_req low is ignored.
module instr_decode_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned OPW      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        alu_zero,
  output logic [3:0]  select1,
  output logic [3:0]  select2,
  output logic [3:0]  select3,
  output logic        RegDst,
  output logic        RegWrite,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic [15:0] imm_out,
  output logic [15:0] pc_out,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_R_LO = OPW'(1);
  localparam logic [OPW-1:0] OP_R_HI = OPW'(7);
  localparam logic [OPW-1:0] OP_I_LO = OPW'(8);
  localparam logic [OPW-1:0] OP_I_HI = OPW'(11);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(12);
  localparam logic [OPW-1:0] OP_HALT = OPW'(14);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(15);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_req;
  logic        r_regwrite;
  logic        r_halted;

  logic [OPW-1:0] w_op;
  logic           w_is_r;
  logic           w_is_i;
  logic           w_is_alu;
  logic [15:0]    w_imm;
  logic [15:0]    w_br_target;
  logic [15:0]    w_jmp_target;

  // Instruction field decode from the latched IR
  always_comb begin
    w_op         = r_ir[15 -: OPW];
    w_is_r       = (w_op >= OP_R_LO) && (w_op <= OP_R_HI);
    w_is_i       = (w_op >= OP_I_LO) && (w_op <= OP_I_HI);
    w_is_alu     = w_is_r || w_is_i;
    w_imm        = {{12{r_ir[3]}}, r_ir[3:0]};
    // r_pc already points past the branch when EXEC evaluates it
    w_br_target  = r_pc + w_imm;
    w_jmp_target = {r_pc[15:12], r_ir[11:0]};
  end

  // Sequencer: PC, IR and the registered handshake / write / halt outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 16'h0000;
      r_req      <= 1'b0;
      r_regwrite <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_req <= 1'b1;
          if (r_req && imem_ack) begin
            r_ir    <= imem_data;
            r_pc    <= r_pc + 16'd1;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_alu) begin
            r_regwrite <= 1'b1;
            r_state    <= S_WB;
          end else if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_req   <= 1'b1;
            r_state <= S_FETCH;
            if (w_op == OP_BEQ && alu_zero) begin
              r_pc <= w_br_target;
            end else if (w_op == OP_JMP) begin
              r_pc <= w_jmp_target;
            end
          end
        end
        S_WB: begin
          r_regwrite <= 1'b0;
          r_req      <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Output mapping: decode controls follow IR, which is stable from DECODE to WB
  always_comb begin
    imem_req  = r_req;
    imem_addr = r_pc;
    pc_out    = r_pc;
    select1   = r_ir[11:8];
    select2   = r_ir[7:4];
    select3   = r_ir[3:0];
    RegDst    = w_is_r;
    alu_src   = w_is_i;
    alu_op    = w_is_alu ? 4'(w_op) : 4'h0;
    imm_out   = w_imm;
    RegWrite  = r_regwrite;
    halted    = r_halted;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Testbench for instr_decode_ctrl: directed scenarios plus randomized
// instruction streams checked against a PC/decode reference model.
module tb_instr_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        alu_zero;
  logic [3:0]  select1, select2, select3;
  logic        RegDst, RegWrite, alu_src, halted;
  logic [3:0]  alu_op;
  logic [15:0] imm_out, pc_out;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_pc;

  typedef struct packed {
    logic        timeout;
    logic        stable;
    logic        req_dec;
    logic        halted;
    logic [15:0] addr;
    logic [15:0] next_addr;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  s3;
    logic        regdst;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [15:0] imm;
    int          rw_count;
    int          rw_cycle;
    int          lat;
  } obs_t;

  instr_decode_ctrl #(.RESET_PC(16'h0000), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .alu_zero(alu_zero),
    .select1(select1), .select2(select2), .select3(select3),
    .RegDst(RegDst), .RegWrite(RegWrite), .alu_op(alu_op),
    .alu_src(alu_src), .imm_out(imm_out), .pc_out(pc_out),
    .halted(halted), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sext4(input logic [3:0] f);
    return (int'(f) >= 8) ? int'(f) - 16 : int'(f);
  endfunction

  function automatic bit model_is_r(input logic [15:0] instr);
    return (int'(instr[15:12]) >= 1) && (int'(instr[15:12]) <= 7);
  endfunction

  function automatic bit model_is_i(input logic [15:0] instr);
    return (int'(instr[15:12]) >= 8) && (int'(instr[15:12]) <= 11);
  endfunction

  function automatic logic [15:0] model_next_pc(input logic [15:0] fetch_addr,
                                                input logic [15:0] instr,
                                                input logic zero);
    int seq;
    int op;
    seq = (int'(fetch_addr) + 1) % 65536;
    op  = int'(instr[15:12]);
    if (op == 12 && zero) return 16'((seq + sext4(instr[3:0]) + 65536) % 65536);
    if (op == 15) return 16'((seq / 4096) * 4096 + int'(instr[11:0]));
    return 16'(seq);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    alu_zero  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from its fetch to the next fetch request (or halt).
  // Junk data with ack high is driven outside FETCH to exercise ack-ignoring.
  task automatic exec_instr(input logic [15:0] instr, input logic zero,
                            input int waits, output obs_t o);
    int n;
    bit done;
    o = '0;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      o.timeout = 1'b1;
      return;
    end
    o.addr   = imem_addr;
    o.stable = 1'b1;
    for (int w = 0; w < waits; w++) begin
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== o.addr || pc_out !== o.addr) o.stable = 1'b0;
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    alu_zero  = zero;
    @(negedge clk);
    n = 1;
    imem_data = 16'($urandom);
    o.req_dec = imem_req;
    o.s1      = select1;
    o.s2      = select2;
    o.s3      = select3;
    o.regdst  = RegDst;
    o.alusrc  = alu_src;
    o.aluop   = alu_op;
    o.imm     = imm_out;
    done = 1'b0;
    while (!done) begin
      if (RegWrite === 1'b1) begin
        o.rw_count = o.rw_count + 1;
        o.rw_cycle = n;
      end
      if (n > 1 && (imem_req === 1'b1 || halted === 1'b1)) begin
        o.lat       = n;
        o.halted    = halted;
        o.next_addr = imem_addr;
        done = 1'b1;
      end else if (n >= 10) begin
        o.timeout = 1'b1;
        done = 1'b1;
      end else begin
        if (n > 1 && (select1 !== o.s1 || select2 !== o.s2 || select3 !== o.s3 ||
                      RegDst !== o.regdst || alu_src !== o.alusrc ||
                      alu_op !== o.aluop || imm_out !== o.imm)) o.stable = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    imem_ack = 1'b0;
    alu_zero = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    alu_zero  = 1'b0;
    #12;
    checks++;
    if ({imem_req, RegWrite, RegDst, alu_src, halted} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/rw/dst/src/halt got %b want 00000",
               {imem_req, RegWrite, RegDst, alu_src, halted});
    end
    checks++;
    if ({select1, select2, select3, alu_op} !== 16'h0000 || imm_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_decode: sel/aluop got %h imm got %h want 0", {select1, select2, select3, alu_op}, imm_out);
    end
    checks++;
    if (pc_out !== 16'h0000 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_pc: got %h/%h want 0000", pc_out, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL first_req: got %b want 1", imem_req);
    end
    ref_pc = 16'h0000;
  endtask

  task automatic test_r_type();
    obs_t o;
    exec_instr(16'h1235, 1'b0, 0, o);
    checks++;
    if (o.timeout !== 1'b0 || o.addr !== ref_pc) begin
      errors++;
      $display("FAIL r_fetch: timeout %b addr %h want %h", o.timeout, o.addr, ref_pc);
    end
    checks++;
    if ({o.s1, o.s2, o.s3} !== 12'h235 || o.aluop !== 4'h1 || o.regdst !== 1'b1 || o.alusrc !== 1'b0) begin
      errors++;
      $display("FAIL r_decode: sel %h aluop %h dst %b src %b want 235 1 1 0", {o.s1, o.s2, o.s3}, o.aluop, o.regdst, o.alusrc);
    end
    checks++;
    if (o.rw_count != 1 || o.rw_cycle != 3 || o.lat != 4 || o.req_dec !== 1'b0 || o.stable !== 1'b1) begin
      errors++;
      $display("FAIL r_timing: rw %0d at %0d lat %0d reqdec %b stable %b want 1 3 4 0 1",
               o.rw_count, o.rw_cycle, o.lat, o.req_dec, o.stable);
    end
    ref_pc = model_next_pc(ref_pc, 16'h1235, 1'b0);
    checks++;
    if (o.next_addr !== ref_pc) begin
      errors++;
      $display("FAIL r_next_addr: got %h want %h", o.next_addr, ref_pc);
    end
  endtask

  task automatic test_i_type();
    obs_t o;
    exec_instr(16'h8A4F, 1'b0, 0, o);
    checks++;
    if (o.timeout !== 1'b0 || o.addr !== ref_pc) begin
      errors++;
      $display("FAIL i_fetch: timeout %b addr %h want %h", o.timeout, o.addr, ref_pc);
    end
    checks++;
    if (o.s1 !== 4'hA || o.s2 !== 4'h4 || o.regdst !== 1'b0 || o.alusrc !== 1'b1 ||
        o.imm !== 16'hFFFF || o.aluop !== 4'h8) begin
      errors++;
      $display("FAIL i_decode: s1 %h s2 %h dst %b src %b imm %h aluop %h want a 4 0 1 ffff 8",
               o.s1, o.s2, o.regdst, o.alusrc, o.imm, o.aluop);
    end
    checks++;
    if (o.rw_count != 1 || o.rw_cycle != 3 || o.stable !== 1'b1) begin
      errors++;
      $display("FAIL i_regwrite: count %0d cycle %0d stable %b want 1 3 1", o.rw_count, o.rw_cycle, o.stable);
    end
    ref_pc = model_next_pc(ref_pc, 16'h8A4F, 1'b0);
  endtask

  task automatic test_wait_stall();
    obs_t o;
    exec_instr(16'h0000, 1'b0, 5, o);
    checks++;
    if (o.timeout !== 1'b0 || o.stable !== 1'b1 || o.addr !== ref_pc) begin
      errors++;
      $display("FAIL stall_hold: timeout %b stable %b addr %h want 0 1 %h", o.timeout, o.stable, o.addr, ref_pc);
    end
    ref_pc = model_next_pc(ref_pc, 16'h0000, 1'b0);
    checks++;
    if (o.next_addr !== ref_pc || o.rw_count != 0 || o.lat != 3) begin
      errors++;
      $display("FAIL stall_next: addr %h rw %0d lat %0d want %h 0 3", o.next_addr, o.rw_count, o.lat, ref_pc);
    end
  endtask

  task automatic test_beq();
    obs_t o;
    logic [15:0] instr [4] = '{16'hF010, 16'hC00E, 16'hF010, 16'hC00E};
    logic        zero  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] want  [4] = '{16'h0010, 16'h000F, 16'h0010, 16'h0011};
    for (int k = 0; k < 4; k++) begin
      exec_instr(instr[k], zero[k], 0, o);
      ref_pc = model_next_pc(ref_pc, instr[k], zero[k]);
      checks++;
      if (o.timeout !== 1'b0 || o.next_addr !== want[k] || o.next_addr !== ref_pc || o.rw_count != 0) begin
        errors++;
        $display("FAIL branch_step%0d: timeout %b next %h rw %0d want %h rw 0",
                 k, o.timeout, o.next_addr, o.rw_count, want[k]);
      end
    end
  endtask

  // Walks the PC through pages: JMP to the page's last word, then a NOP rolls into the next page
  task automatic hop_to(input logic [15:0] target, input string tag);
    obs_t o;
    logic [15:0] instr;
    int guard = 0;
    while (ref_pc != target && guard < 64) begin
      instr = (ref_pc[11:0] == 12'hFFF) ? 16'h0000 : 16'hFFFF;
      if (ref_pc[15:12] == target[15:12] && ref_pc[11:0] != 12'hFFF) instr = {4'hF, target[11:0]};
      exec_instr(instr, 1'b0, $urandom_range(0, 1), o);
      ref_pc = model_next_pc(ref_pc, instr, 1'b0);
      checks++;
      if (o.timeout !== 1'b0 || o.next_addr !== ref_pc) begin
        errors++;
        $display("FAIL %s_hop: timeout %b next %h want %h", tag, o.timeout, o.next_addr, ref_pc);
      end
      guard++;
    end
  endtask

  task automatic test_jmp();
    obs_t o;
    hop_to(16'h5000, "jmp");
    exec_instr(16'hF123, 1'b0, 0, o);
    checks++;
    if (o.addr !== 16'h5000 || o.next_addr !== 16'h5123 || o.rw_count != 0 || o.lat != 3) begin
      errors++;
      $display("FAIL jmp_target: from %h next %h rw %0d lat %0d want 5000 5123 0 3",
               o.addr, o.next_addr, o.rw_count, o.lat);
    end
    ref_pc = model_next_pc(ref_pc, 16'hF123, 1'b0);
  endtask

  task automatic test_wrap();
    obs_t o;
    hop_to(16'hFFFF, "wrap");
    exec_instr(16'h0000, 1'b0, 0, o);
    checks++;
    if (o.addr !== 16'hFFFF || o.next_addr !== 16'h0000) begin
      errors++;
      $display("FAIL pc_wrap: from %h next %h want ffff 0000", o.addr, o.next_addr);
    end
    ref_pc = model_next_pc(ref_pc, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] instr;
    logic        zero;
    logic [15:0] exp_imm;
    logic [3:0]  exp_aluop;
    bit          alu;
    for (int k = 0; k < 40; k++) begin
      instr = 16'($urandom);
      if (instr[15:12] == 4'hE) instr[15:12] = 4'h0;
      zero = 1'($urandom_range(0, 1));
      exec_instr(instr, zero, $urandom_range(0, 3), o);
      alu       = model_is_r(instr) || model_is_i(instr);
      exp_imm   = 16'(sext4(instr[3:0]));
      exp_aluop = alu ? instr[15:12] : 4'h0;
      checks++;
      if (o.timeout !== 1'b0 || o.addr !== ref_pc || o.stable !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_fetch: instr %h timeout %b addr %h stable %b want %h",
                 k, instr, o.timeout, o.addr, o.stable, ref_pc);
      end
      checks++;
      if (o.s1 !== instr[11:8] || o.s2 !== instr[7:4] || o.s3 !== instr[3:0] ||
          o.regdst !== model_is_r(instr) || o.alusrc !== model_is_i(instr) ||
          o.aluop !== exp_aluop || o.imm !== exp_imm) begin
        errors++;
        $display("FAIL rnd%0d_decode: instr %h got sel %h dst %b src %b op %h imm %h want dst %b src %b op %h imm %h",
                 k, instr, {o.s1, o.s2, o.s3}, o.regdst, o.alusrc, o.aluop, o.imm,
                 model_is_r(instr), model_is_i(instr), exp_aluop, exp_imm);
      end
      checks++;
      if (o.rw_count != (alu ? 1 : 0) || (alu && o.rw_cycle != 3) || o.lat != (alu ? 4 : 3)) begin
        errors++;
        $display("FAIL rnd%0d_timing: instr %h rw %0d at %0d lat %0d want rw %0d lat %0d",
                 k, instr, o.rw_count, o.rw_cycle, o.lat, alu ? 1 : 0, alu ? 4 : 3);
      end
      ref_pc = model_next_pc(ref_pc, instr, zero);
      checks++;
      if (o.next_addr !== ref_pc) begin
        errors++;
        $display("FAIL rnd%0d_next_pc: instr %h zero %b got %h want %h", k, instr, zero, o.next_addr, ref_pc);
      end
    end
  endtask

  task automatic test_reset_mid_wb();
    obs_t o;
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    imem_ack  = 1'b1;
    imem_data = 16'h2467;
    @(negedge clk);
    imem_ack = 1'b0;
    n = 0;
    while (RegWrite !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL midwb_reach: RegWrite got %b want 1 within 6 cycles", RegWrite);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || pc_out !== 16'h0000 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL midwb_async: rw %b pc %h req %b want 0 0000 0", RegWrite, pc_out, imem_req);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    ref_pc = 16'h0000;
    exec_instr(16'h0000, 1'b0, 0, o);
    checks++;
    if (o.timeout !== 1'b0 || o.addr !== 16'h0000 || o.rw_count != 0) begin
      errors++;
      $display("FAIL midwb_refetch: timeout %b addr %h rw %0d want 0 0000 0", o.timeout, o.addr, o.rw_count);
    end
    ref_pc = model_next_pc(ref_pc, 16'h0000, 1'b0);
  endtask

  task automatic test_halt();
    obs_t o;
    int bad = 0;
    exec_instr(16'hE000, 1'b0, 0, o);
    checks++;
    if (o.timeout !== 1'b0 || o.halted !== 1'b1 || o.rw_count != 0) begin
      errors++;
      $display("FAIL halt_enter: timeout %b halted %b rw %0d want 0 1 0", o.timeout, o.halted, o.rw_count);
    end
    imem_ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      imem_data = 16'($urandom);
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b1 || RegWrite !== 1'b0) bad++;
    end
    imem_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: %0d cycles left halt or requested, want 0", bad);
    end
  endtask

  // Sequence of scenarios and final report
  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_wait_stall();
    test_beq();
    test_jmp();
    test_wrap();
    test_random();
    test_reset_mid_wb();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
